// File: rtl/decode_control_pipe_if.sv
// -----------------------------------------------------------------------------
// decode_control_pipe_if
// Bundles the fetch-side handshake, the issue-side handshake and the branch
// bookkeeping signals of decode_control_pipe into one interface.
//
// Optional feature macro: DECODE_STATS_EN (adds the per-class pop counters
// n_branch_o, n_store_o, n_fround_o).
//
// Signals (direction as seen by the decoder, i.e. the slave modport):
//   in_valid_i   in   opcode valid from fetch
//   in_ready_o   out  decoder accepts an opcode this cycle
//   op_i         in   opcode, OP_W bits
//   out_valid_o  out  decoded opcode valid
//   out_ready_i  in   issue accepts the decoded opcode
//   out_op_o     out  registered opcode
//   fround_o     out  class: float round mode
//   branch_o     out  class: conditional branch
//   store_o      out  class: store
//   illegal_o    out  upper opcode bits non-zero
//   br_resolve_i in   one branch resolved (pulse)
//   flush_i      in   drop output stage and clear branch count
//   br_cnt_o     out  unresolved branch count
//   br_err_o     out  sticky resolve-without-branch error
//   n_*_o        out  per-class pop counters (DECODE_STATS_EN only)
// -----------------------------------------------------------------------------
interface decode_control_pipe_if #(
    parameter int OP_W  = 8,
    parameter int CNT_W = 16
);

    logic            in_valid_i;
    logic            in_ready_o;
    logic [OP_W-1:0] op_i;
    logic            out_valid_o;
    logic            out_ready_i;
    logic [OP_W-1:0] out_op_o;
    logic            fround_o;
    logic            branch_o;
    logic            store_o;
    logic            illegal_o;
    logic            br_resolve_i;
    logic            flush_i;
    logic [3:0]      br_cnt_o;
    logic            br_err_o;
`ifdef DECODE_STATS_EN
    logic [CNT_W-1:0] n_branch_o;
    logic [CNT_W-1:0] n_store_o;
    logic [CNT_W-1:0] n_fround_o;
`endif

    // Reject widths the decoder cannot handle at elaboration time.
    if (OP_W < 8 || CNT_W < 1) begin : gBadParams
        $error("decode_control_pipe_if: OP_W must be >= 8 and CNT_W >= 1");
    end

    // Decoder side.
    modport slave (
        input  in_valid_i, op_i, out_ready_i, br_resolve_i, flush_i,
        output in_ready_o, out_valid_o, out_op_o, fround_o, branch_o,
               store_o, illegal_o, br_cnt_o, br_err_o
`ifdef DECODE_STATS_EN
        , output n_branch_o, n_store_o, n_fround_o
`endif
    );

    // Fetch/issue side.
    modport master (
        output in_valid_i, op_i, out_ready_i, br_resolve_i, flush_i,
        input  in_ready_o, out_valid_o, out_op_o, fround_o, branch_o,
               store_o, illegal_o, br_cnt_o, br_err_o
`ifdef DECODE_STATS_EN
        , input n_branch_o, n_store_o, n_fround_o
`endif
    );

endinterface

// File: rtl/decode_control_pipe.sv
// -----------------------------------------------------------------------------
// decode_control_pipe
// Registered opcode-class decoder sitting between fetch and issue. Each opcode
// accepted over the valid/ready handshake is classified as fround, branch,
// store or illegal and presented one cycle later. Unresolved branches are
// counted; fetch is stalled (HOLD state) while BR_DEPTH are in flight.
//
// Optional feature macro: DECODE_STATS_EN adds saturating per-class counters
// of popped opcodes (n_branch_o, n_store_o, n_fround_o), CNT_W bits each.
//
// Ports:
//   clk     in   clock, all state updates on the rising edge
//   nreset  in   synchronous reset, active low
//   bus     slave modport of decode_control_pipe_if (handshakes, decoded
//           class bits, branch count/error, optional statistics)
// -----------------------------------------------------------------------------
module decode_control_pipe #(
    parameter int OP_W     = 8,
    parameter int BR_DEPTH = 2,
    parameter int CNT_W    = 16
) (
    input  logic                  clk,
    input  logic                  nreset,
    decode_control_pipe_if.slave  bus
);

    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } state_e;

    // Reject configurations outside the supported range.
    if (OP_W < 8 || BR_DEPTH < 1 || BR_DEPTH > 15 || CNT_W < 1) begin : gBadParams
        $error("decode_control_pipe: parameter out of range");
    end

    localparam logic [3:0] BrDepth = 4'(BR_DEPTH);

    state_e          state_q, state_d;
    logic            outValid_q, outValid_d;
    logic [OP_W-1:0] outOp_q, outOp_d;
    logic            fround_q, fround_d;
    logic            branch_q, branch_d;
    logic            store_q, store_d;
    logic            illegal_q, illegal_d;
    logic [3:0]      brCnt_q, brCnt_d;
    logic            brErr_q, brErr_d;

    logic            inReady;
    logic            accept;
    logic            pop;
    logic            opHigh;
    logic            decFround;
    logic            decBranch;
    logic            decStore;

    // Anything set above bit 7 makes the opcode illegal.
    if (OP_W > 8) begin : gHighBits
        assign opHigh = |bus.op_i[OP_W-1:8];
    end else begin : gNoHighBits
        assign opHigh = 1'b0;
    end

    // Class decode of the incoming opcode; illegal opcodes get no class.
    always_comb begin
        decFround = 1'b0;
        decBranch = 1'b0;
        decStore  = 1'b0;
        if (!opHigh) begin
            decFround = (bus.op_i[7:0] == 8'b1101_0110);
            decStore  = (bus.op_i[7:4] == 4'b1111);
            decBranch = (bus.op_i[7:6] == 2'b11) &&
                        (((bus.op_i[5:4] == 2'b01) &&
                          (bus.op_i[3] || (bus.op_i[3:0] == 4'b0111))) ||
                         (bus.op_i[5:4] == 2'b10));
        end
    end

    // Handshake: the stage can take a new opcode when it is empty or being
    // drained, fetch is not stalled on branches, and no flush is in progress.
    always_comb begin
        inReady = (~outValid_q | bus.out_ready_i) & (state_q == RUN) & ~bus.flush_i;
        accept  = bus.in_valid_i & inReady;
        pop     = outValid_q & bus.out_ready_i;
    end

    // Next state of the output stage, branch counter, error flag and FSM.
    // A simultaneous branch accept and resolve cancel out, and a flush wins
    // over both (its resolve pulse is dropped without raising the error).
    always_comb begin
        state_d    = state_q;
        outValid_d = outValid_q;
        outOp_d    = outOp_q;
        fround_d   = fround_q;
        branch_d   = branch_q;
        store_d    = store_q;
        illegal_d  = illegal_q;
        brCnt_d    = brCnt_q;
        brErr_d    = brErr_q;

        if (bus.flush_i) begin
            outValid_d = 1'b0;
            brCnt_d    = 4'd0;
            state_d    = RUN;
        end else begin
            if (accept) begin
                outValid_d = 1'b1;
                outOp_d    = bus.op_i;
                fround_d   = decFround;
                branch_d   = decBranch;
                store_d    = decStore;
                illegal_d  = opHigh;
            end else if (pop) begin
                outValid_d = 1'b0;
            end

            if ((accept && decBranch) && !bus.br_resolve_i) begin
                brCnt_d = brCnt_q + 4'd1;
            end else if (bus.br_resolve_i && !(accept && decBranch)) begin
                if (brCnt_q == 4'd0) begin
                    brErr_d = 1'b1;
                end else begin
                    brCnt_d = brCnt_q - 4'd1;
                end
            end

            unique case (state_q)
                RUN:  if (brCnt_d == BrDepth) state_d = HOLD;
                HOLD: if (brCnt_d < BrDepth)  state_d = RUN;
                default: state_d = RUN;
            endcase
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            state_q    <= RUN;
            outValid_q <= 1'b0;
            outOp_q    <= '0;
            fround_q   <= 1'b0;
            branch_q   <= 1'b0;
            store_q    <= 1'b0;
            illegal_q  <= 1'b0;
            brCnt_q    <= 4'd0;
            brErr_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            outValid_q <= outValid_d;
            outOp_q    <= outOp_d;
            fround_q   <= fround_d;
            branch_q   <= branch_d;
            store_q    <= store_d;
            illegal_q  <= illegal_d;
            brCnt_q    <= brCnt_d;
            brErr_q    <= brErr_d;
        end
    end

    assign bus.in_ready_o  = inReady;
    assign bus.out_valid_o = outValid_q;
    assign bus.out_op_o    = outOp_q;
    assign bus.fround_o    = fround_q;
    assign bus.branch_o    = branch_q;
    assign bus.store_o     = store_q;
    assign bus.illegal_o   = illegal_q;
    assign bus.br_cnt_o    = brCnt_q;
    assign bus.br_err_o    = brErr_q;

`ifdef DECODE_STATS_EN
    logic [CNT_W-1:0] nBranch_q, nBranch_d;
    logic [CNT_W-1:0] nStore_q, nStore_d;
    logic [CNT_W-1:0] nFround_q, nFround_d;

    // Per-class pop counters; they saturate and ignore flush.
    always_comb begin
        nBranch_d = nBranch_q;
        nStore_d  = nStore_q;
        nFround_d = nFround_q;
        if (pop && branch_q && !(&nBranch_q)) nBranch_d = nBranch_q + 1'b1;
        if (pop && store_q  && !(&nStore_q))  nStore_d  = nStore_q + 1'b1;
        if (pop && fround_q && !(&nFround_q)) nFround_d = nFround_q + 1'b1;
    end

    // Statistics registers.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            nBranch_q <= '0;
            nStore_q  <= '0;
            nFround_q <= '0;
        end else begin
            nBranch_q <= nBranch_d;
            nStore_q  <= nStore_d;
            nFround_q <= nFround_d;
        end
    end

    assign bus.n_branch_o = nBranch_q;
    assign bus.n_store_o  = nStore_q;
    assign bus.n_fround_o = nFround_q;
`else
`endif

endmodule

// File: tb/tb_decode_control_pipe.sv
// -----------------------------------------------------------------------------
// tb_decode_control_pipe
// Self-checking bench for decode_control_pipe: directed scenarios followed by
// randomized traffic, all checked against a cycle-level behavioural model.
// Built with OP_W=10 so that illegal opcodes can be produced, and CNT_W=2 so
// that statistics saturation is reachable when DECODE_STATS_EN is defined.
// -----------------------------------------------------------------------------
module tb_decode_control_pipe;

   localparam int OP_W     = 10;
   localparam int BR_DEPTH = 2;
   localparam int CNT_W    = 2;

   logic clock = 1'b0;
   logic nreset;

   int checks = 0;
   int errors = 0;

   // Behavioural model state
   bit              mValid;
   logic [OP_W-1:0] mOp;
   bit              mFround, mBranch, mStore, mIllegal;
   int              mCnt;
   bit              mErr;
   bit              mJustReset;
   int              mNBranch, mNStore, mNFround;

   // Free-running clock
   always #5 clock = ~clock;

   decode_control_pipe_if #(.OP_W(OP_W), .CNT_W(CNT_W)) bus ();

   decode_control_pipe #(.OP_W(OP_W), .BR_DEPTH(BR_DEPTH), .CNT_W(CNT_W)) dut (
      .clk    (clock),
      .nreset (nreset),
      .bus    (bus)
   );

   // Single comparison point: counts every check and reports mismatches
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
      end
   endtask

   // Opcode classes straight from the decode rules
   function automatic void classify(input logic [OP_W-1:0] op, output bit fr,
                                    output bit br, output bit st, output bit il);
      logic [7:0] lo;
      lo = op[7:0];
      il = (op >> 8) != 0;
      fr = !il && (lo == 8'hD6);
      st = !il && (lo[7:4] == 4'hF);
      br = !il && (lo[7:6] == 2'b11) &&
           ((lo[5:4] == 2'b01 && (lo[3] || lo[3:0] == 4'h7)) || lo[5:4] == 2'b10);
   endfunction

   function automatic bit modelReady();
      return (!mValid || bus.out_ready_i) && (mCnt < BR_DEPTH) && !bus.flush_i;
   endfunction

   // Advance the model by one clock edge using the inputs currently applied
   task automatic modelUpdate(input bit ready);
      bit acc, pop, fr, br, st, il;
      mJustReset = 1'b0;
      if (!nreset) begin
         mValid = 0; mOp = '0; mFround = 0; mBranch = 0; mStore = 0; mIllegal = 0;
         mCnt = 0; mErr = 0; mNBranch = 0; mNStore = 0; mNFround = 0;
         mJustReset = 1'b1;
         return;
      end
      acc = bus.in_valid_i && ready;
      pop = mValid && bus.out_ready_i;
      if (pop && mBranch) mNBranch = (mNBranch == (1 << CNT_W) - 1) ? mNBranch : mNBranch + 1;
      if (pop && mStore)  mNStore  = (mNStore  == (1 << CNT_W) - 1) ? mNStore  : mNStore + 1;
      if (pop && mFround) mNFround = (mNFround == (1 << CNT_W) - 1) ? mNFround : mNFround + 1;
      if (bus.flush_i) begin
         mValid = 0;
         mCnt   = 0;
         return;
      end
      classify(bus.op_i, fr, br, st, il);
      if (acc) begin
         mValid = 1; mOp = bus.op_i; mFround = fr; mBranch = br; mStore = st; mIllegal = il;
      end else if (pop) begin
         mValid = 0;
      end
      if (acc && br && !bus.br_resolve_i) mCnt++;
      else if (bus.br_resolve_i && !(acc && br)) begin
         if (mCnt == 0) mErr = 1;
         else mCnt--;
      end
   endtask

   task automatic compareOutputs();
      checkOutput("out_valid", bus.out_valid_o, mValid);
      checkOutput("br_cnt", bus.br_cnt_o, mCnt);
      checkOutput("br_err", bus.br_err_o, mErr);
      if (mValid || mJustReset) begin
         checkOutput("out_op", bus.out_op_o, mOp);
         checkOutput("fround", bus.fround_o, mFround);
         checkOutput("branch", bus.branch_o, mBranch);
         checkOutput("store", bus.store_o, mStore);
         checkOutput("illegal", bus.illegal_o, mIllegal);
      end
`ifdef DECODE_STATS_EN
      checkOutput("n_branch", bus.n_branch_o, mNBranch);
      checkOutput("n_store", bus.n_store_o, mNStore);
      checkOutput("n_fround", bus.n_fround_o, mNFround);
`endif
   endtask

   // Drive one cycle of inputs, check in_ready before the edge and the
   // registered outputs just after it
   task automatic applyStimulus(input bit valid, input logic [OP_W-1:0] op,
                                input bit outReady, input bit resolve, input bit flush);
      bit ready;
      bus.in_valid_i   = valid;
      bus.op_i         = op;
      bus.out_ready_i  = outReady;
      bus.br_resolve_i = resolve;
      bus.flush_i      = flush;
      #2;
      ready = modelReady();
      if (nreset) checkOutput("in_ready", bus.in_ready_o, ready);
      @(posedge clock);
      modelUpdate(ready);
      #1;
      compareOutputs();
   endtask

   function automatic logic [OP_W-1:0] randomOp();
      logic [OP_W-1:0] op;
      case ($urandom_range(0, 5))
         0: op = 10'h0D6;
         1: op = 10'h0F0 | 10'($urandom_range(0, 15));
         2: op = 10'h0D0 | 10'($urandom_range(0, 15));
         3: op = 10'h0E0 | 10'($urandom_range(0, 15));
         4: op = 10'($urandom_range(256, 1023));
         default: op = 10'($urandom_range(0, 255));
      endcase
      return op;
   endfunction

   initial begin
      nreset = 1'b0;
      bus.in_valid_i = 0; bus.op_i = '0; bus.out_ready_i = 0;
      bus.br_resolve_i = 0; bus.flush_i = 0;
      mValid = 0; mOp = '0; mCnt = 0; mErr = 0; mJustReset = 0;
      mFround = 0; mBranch = 0; mStore = 0; mIllegal = 0;
      mNBranch = 0; mNStore = 0; mNFround = 0;
      @(posedge clock);
      #1;

      // 1: reset held two cycles with valid asserted
      applyStimulus(1, 10'h0D6, 1, 0, 0);
      applyStimulus(1, 10'h0D6, 1, 0, 0);
      nreset = 1'b1;
      bus.in_valid_i = 0;
      bus.out_ready_i = 0;
      #1;
      checkOutput("t1_in_ready", bus.in_ready_o, 1);

      // 2: one of each class streamed back to back
      applyStimulus(1, 10'h0D6, 1, 0, 0);
      checkOutput("t2_fround", bus.fround_o, 1);
      applyStimulus(1, 10'h0D8, 1, 0, 0);
      checkOutput("t2_branch", bus.branch_o, 1);
      applyStimulus(1, 10'h0F3, 1, 0, 0);
      checkOutput("t2_store", bus.store_o, 1);
      applyStimulus(1, 10'h012, 1, 0, 0);
      checkOutput("t2_cnt", bus.br_cnt_o, 1);

      // 3: branch depth stall and release
      applyStimulus(0, '0, 1, 0, 1);
      applyStimulus(1, 10'h0E0, 1, 0, 0);
      applyStimulus(1, 10'h0D7, 1, 0, 0);
      applyStimulus(1, 10'h0D6, 1, 0, 0);
      checkOutput("t3_cnt", bus.br_cnt_o, 2);
      checkOutput("t3_stalled", bus.in_ready_o, 0);
      applyStimulus(1, 10'h0D6, 1, 1, 0);
      applyStimulus(1, 10'h0D6, 1, 0, 0);
      checkOutput("t3_out_op", bus.out_op_o, 10'h0D6);

      // 4: accept and resolve cancel; resolve at zero is an error
      applyStimulus(0, '0, 1, 0, 1);
      applyStimulus(1, 10'h0E0, 1, 0, 0);
      applyStimulus(1, 10'h0E5, 1, 1, 0);
      checkOutput("t4_cnt_same", bus.br_cnt_o, 1);
      applyStimulus(0, '0, 1, 1, 0);
      applyStimulus(0, '0, 1, 1, 0);
      checkOutput("t4_err", bus.br_err_o, 1);
      checkOutput("t4_cnt_zero", bus.br_cnt_o, 0);

      // 5: back-pressure holds the stage, then flush empties it
      applyStimulus(1, 10'h0E0, 1, 0, 0);
      applyStimulus(1, 10'h0F3, 1, 0, 0);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1, 10'h012, 0, 0, 0);
         checkOutput("t5_hold_op", bus.out_op_o, 10'h0F3);
      end
      applyStimulus(0, '0, 0, 0, 1);
      checkOutput("t5_flush_valid", bus.out_valid_o, 0);
      checkOutput("t5_flush_cnt", bus.br_cnt_o, 0);

      // 6: illegal opcode and statistics saturation
      nreset = 1'b0;
      applyStimulus(0, '0, 0, 0, 0);
      nreset = 1'b1;
      applyStimulus(1, 10'h1D6, 1, 0, 0);
      checkOutput("t6_illegal", bus.illegal_o, 1);
      checkOutput("t6_fround", bus.fround_o, 0);
      for (int i = 0; i < 5; i++) applyStimulus(1, 10'h0F0 + 10'(i), 1, 0, 0);
      applyStimulus(0, '0, 1, 0, 0);
`ifdef DECODE_STATS_EN
      checkOutput("t6_n_store", bus.n_store_o, 3);
`endif

      // Randomized traffic against the model
      for (int i = 0; i < 2000; i++) begin
         applyStimulus($urandom_range(0, 99) < 80, randomOp(),
                       $urandom_range(0, 99) < 70, $urandom_range(0, 99) < 20,
                       $urandom_range(0, 99) < 3);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
